// File: rtl/pipelined_control_unit.sv
// Pipelined RV32I control unit: decodes in Decode and carries the control word
// through the D/E, E/M and M/W registers. Branches and jumps resolve in Execute.
// Ports: op_D/funct3_D/funct7_5_D in; FlushE bubble; Z/N/C/V flags; ImmSrcD and PCSrcE combinational.
module pipelined_control_unit #(
  parameter int OP_WIDTH         = 7,
  parameter int FUNCT3_WIDTH     = 3,
  parameter int ALU_CTRL_WIDTH   = 4,
  parameter int IMM_SRC_WIDTH    = 3,
  parameter int RESULT_SRC_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [OP_WIDTH-1:0]         op_D,
  input  logic [FUNCT3_WIDTH-1:0]     funct3_D,
  input  logic                        funct7_5_D,
  input  logic                        FlushE,
  input  logic                        ZeroE,
  input  logic                        NegE,
  input  logic                        CarryE,
  input  logic                        OvfE,
  output logic [IMM_SRC_WIDTH-1:0]    ImmSrcD,
  output logic [ALU_CTRL_WIDTH-1:0]   ALUControlE,
  output logic                        ALUSrcE,
  output logic                        PCSrcE,
  output logic                        PCTargetSrcE,
  output logic                        MemWriteM,
  output logic                        RegWriteM,
  output logic                        RegWriteW,
  output logic [RESULT_SRC_WIDTH-1:0] ResultSrcM,
  output logic [RESULT_SRC_WIDTH-1:0] ResultSrcW,
  output logic                        IllegalE
);

  localparam logic [OP_WIDTH-1:0] OP_LOAD   = OP_WIDTH'(7'b0000011);
  localparam logic [OP_WIDTH-1:0] OP_STORE  = OP_WIDTH'(7'b0100011);
  localparam logic [OP_WIDTH-1:0] OP_RTYPE  = OP_WIDTH'(7'b0110011);
  localparam logic [OP_WIDTH-1:0] OP_IALU   = OP_WIDTH'(7'b0010011);
  localparam logic [OP_WIDTH-1:0] OP_BRANCH = OP_WIDTH'(7'b1100011);
  localparam logic [OP_WIDTH-1:0] OP_JAL    = OP_WIDTH'(7'b1101111);
  localparam logic [OP_WIDTH-1:0] OP_JALR   = OP_WIDTH'(7'b1100111);
  localparam logic [OP_WIDTH-1:0] OP_LUI    = OP_WIDTH'(7'b0110111);

  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD   = ALU_CTRL_WIDTH'(4'b0000);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB   = ALU_CTRL_WIDTH'(4'b0001);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND   = ALU_CTRL_WIDTH'(4'b0010);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR    = ALU_CTRL_WIDTH'(4'b0011);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_XOR   = ALU_CTRL_WIDTH'(4'b0100);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT   = ALU_CTRL_WIDTH'(4'b0101);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLTU  = ALU_CTRL_WIDTH'(4'b0110);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLL   = ALU_CTRL_WIDTH'(4'b0111);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRL   = ALU_CTRL_WIDTH'(4'b1000);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRA   = ALU_CTRL_WIDTH'(4'b1001);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_PASSB = ALU_CTRL_WIDTH'(4'b1010);

  localparam logic [IMM_SRC_WIDTH-1:0] IMM_I = IMM_SRC_WIDTH'(3'b000);
  localparam logic [IMM_SRC_WIDTH-1:0] IMM_S = IMM_SRC_WIDTH'(3'b001);
  localparam logic [IMM_SRC_WIDTH-1:0] IMM_B = IMM_SRC_WIDTH'(3'b010);
  localparam logic [IMM_SRC_WIDTH-1:0] IMM_J = IMM_SRC_WIDTH'(3'b011);
  localparam logic [IMM_SRC_WIDTH-1:0] IMM_U = IMM_SRC_WIDTH'(3'b100);

  localparam logic [RESULT_SRC_WIDTH-1:0] RES_ALU = RESULT_SRC_WIDTH'(2'b00);
  localparam logic [RESULT_SRC_WIDTH-1:0] RES_MEM = RESULT_SRC_WIDTH'(2'b01);
  localparam logic [RESULT_SRC_WIDTH-1:0] RES_PC4 = RESULT_SRC_WIDTH'(2'b10);

  typedef struct packed {
    logic                        reg_write;
    logic                        alu_src;
    logic                        mem_write;
    logic [RESULT_SRC_WIDTH-1:0] result_src;
    logic                        branch;
    logic                        jump;
    logic                        pc_target_src;
    logic [ALU_CTRL_WIDTH-1:0]   alu_ctrl;
    logic [FUNCT3_WIDTH-1:0]     funct3;
    logic                        illegal;
  } ctrl_t;

  ctrl_t                       ctrl_d, ctrl_q;
  logic [IMM_SRC_WIDTH-1:0]    imm_src_d;
  logic                        reg_write_m_q, mem_write_m_q, reg_write_w_q;
  logic [RESULT_SRC_WIDTH-1:0] result_src_m_q, result_src_w_q;
  logic                        branch_cond;
  logic                        f3_reserved;

  // Register-register and register-immediate ops share the funct3 map; 'alt'
  // is instr[30] where it is meaningful and 0 otherwise.
  function automatic logic [ALU_CTRL_WIDTH-1:0] alu_op(input logic [FUNCT3_WIDTH-1:0] f3,
                                                       input logic alt);
    case (f3)
      FUNCT3_WIDTH'(3'b000): alu_op = alt ? ALU_SUB : ALU_ADD;
      FUNCT3_WIDTH'(3'b001): alu_op = ALU_SLL;
      FUNCT3_WIDTH'(3'b010): alu_op = ALU_SLT;
      FUNCT3_WIDTH'(3'b011): alu_op = ALU_SLTU;
      FUNCT3_WIDTH'(3'b100): alu_op = ALU_XOR;
      FUNCT3_WIDTH'(3'b101): alu_op = alt ? ALU_SRA : ALU_SRL;
      FUNCT3_WIDTH'(3'b110): alu_op = ALU_OR;
      default:               alu_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    ctrl_d    = '0;
    imm_src_d = IMM_I;
    case (op_D)
      OP_LOAD: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.result_src = RES_MEM;
        ctrl_d.alu_ctrl   = ALU_ADD;
      end
      OP_STORE: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_ctrl  = ALU_ADD;
        imm_src_d        = IMM_S;
      end
      OP_RTYPE: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_ctrl  = alu_op(funct3_D, funct7_5_D);
      end
      OP_IALU: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        // instr[30] is part of the immediate for addi, so only shifts look at it.
        ctrl_d.alu_ctrl  = alu_op(funct3_D,
                                  funct7_5_D && (funct3_D == FUNCT3_WIDTH'(3'b101)));
      end
      OP_BRANCH: begin
        ctrl_d.branch   = 1'b1;
        ctrl_d.alu_ctrl = ALU_SUB;
        ctrl_d.funct3   = funct3_D;
        imm_src_d       = IMM_B;
      end
      OP_JAL: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = RES_PC4;
        ctrl_d.jump       = 1'b1;
        ctrl_d.alu_ctrl   = ALU_ADD;
        imm_src_d         = IMM_J;
      end
      OP_JALR: begin
        ctrl_d.reg_write     = 1'b1;
        ctrl_d.alu_src       = 1'b1;
        ctrl_d.result_src    = RES_PC4;
        ctrl_d.jump          = 1'b1;
        ctrl_d.pc_target_src = 1'b1;
        ctrl_d.alu_ctrl      = ALU_ADD;
      end
      OP_LUI: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_ctrl  = ALU_PASSB;
        imm_src_d        = IMM_U;
      end
      default: ctrl_d.illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q         <= '0;
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      result_src_m_q <= '0;
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= '0;
    end else begin
      ctrl_q         <= FlushE ? '0 : ctrl_d;
      reg_write_m_q  <= ctrl_q.reg_write;
      mem_write_m_q  <= ctrl_q.mem_write;
      result_src_m_q <= ctrl_q.result_src;
      reg_write_w_q  <= reg_write_m_q;
      result_src_w_q <= result_src_m_q;
    end
  end

  // Flags come from A-B; Carry means no borrow, so A>=B unsigned when set.
  always_comb begin
    case (ctrl_q.funct3)
      FUNCT3_WIDTH'(3'b000): branch_cond = ZeroE;
      FUNCT3_WIDTH'(3'b001): branch_cond = !ZeroE;
      FUNCT3_WIDTH'(3'b100): branch_cond = NegE ^ OvfE;
      FUNCT3_WIDTH'(3'b101): branch_cond = !(NegE ^ OvfE);
      FUNCT3_WIDTH'(3'b110): branch_cond = !CarryE;
      FUNCT3_WIDTH'(3'b111): branch_cond = CarryE;
      default:               branch_cond = 1'b0;
    endcase
  end

  assign f3_reserved  = (ctrl_q.funct3 == FUNCT3_WIDTH'(3'b010)) ||
                        (ctrl_q.funct3 == FUNCT3_WIDTH'(3'b011));

  assign ImmSrcD      = imm_src_d;
  assign ALUControlE  = ctrl_q.alu_ctrl;
  assign ALUSrcE      = ctrl_q.alu_src;
  assign PCTargetSrcE = ctrl_q.pc_target_src;
  assign PCSrcE       = ctrl_q.jump | (ctrl_q.branch & branch_cond);
  assign IllegalE     = ctrl_q.illegal | (ctrl_q.branch & f3_reserved);
  assign MemWriteM    = mem_write_m_q;
  assign RegWriteM    = reg_write_m_q;
  assign ResultSrcM   = result_src_m_q;
  assign RegWriteW    = reg_write_w_q;
  assign ResultSrcW   = result_src_w_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
`timescale 1ns/1ps
module tb_pipelined_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op_D;
  logic [2:0] funct3_D;
  logic       funct7_5_D, FlushE;
  logic       ZeroE, NegE, CarryE, OvfE;
  logic [2:0] ImmSrcD;
  logic [3:0] ALUControlE;
  logic       ALUSrcE, PCSrcE, PCTargetSrcE, MemWriteM, RegWriteM, RegWriteW, IllegalE;
  logic [1:0] ResultSrcM, ResultSrcW;

  pipelined_control_unit dut (
    .clk(clk), .rst(rst), .op_D(op_D), .funct3_D(funct3_D), .funct7_5_D(funct7_5_D),
    .FlushE(FlushE), .ZeroE(ZeroE), .NegE(NegE), .CarryE(CarryE), .OvfE(OvfE),
    .ImmSrcD(ImmSrcD), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .PCSrcE(PCSrcE),
    .PCTargetSrcE(PCTargetSrcE), .MemWriteM(MemWriteM), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .ResultSrcM(ResultSrcM), .ResultSrcW(ResultSrcW),
    .IllegalE(IllegalE)
  );

  always #10 clk = ~clk;

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011,
                         IA = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                         JR = 7'b1100111, LU = 7'b0110111, BAD = 7'b1111111;

  typedef struct packed {
    logic [3:0] alu;
    logic       alusrc, pctsrc, ill, br, jmp;
    logic [2:0] f3;
    logic       rw;
    logic [1:0] rs;
    logic       mw;
  } cw_t;

  cw_t qe[$];
  cw_t e_exp, m_exp, w_exp;
  int  n_chk = 0;
  int  n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? 4'b0001 : 4'b0000;
      3'b001:  return 4'b0111;
      3'b010:  return 4'b0101;
      3'b011:  return 4'b0110;
      3'b100:  return 4'b0100;
      3'b101:  return alt ? 4'b1001 : 4'b1000;
      3'b110:  return 4'b0011;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic cw_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    cw_t c = '0;
    case (op)
      LD: begin c.rw = 1; c.alusrc = 1; c.rs = 2'b01; end
      ST: begin c.alusrc = 1; c.mw = 1; end
      RT: begin c.rw = 1; c.alu = ref_alu(f3, f7); end
      IA: begin c.rw = 1; c.alusrc = 1; c.alu = ref_alu(f3, (f3 == 3'b101) ? f7 : 1'b0); end
      BR: begin c.br = 1; c.alu = 4'b0001; c.f3 = f3; end
      JL: begin c.rw = 1; c.rs = 2'b10; c.jmp = 1; end
      JR: begin c.rw = 1; c.alusrc = 1; c.rs = 2'b10; c.jmp = 1; c.pctsrc = 1; end
      LU: begin c.rw = 1; c.alusrc = 1; c.alu = 4'b1010; end
      default: c.ill = 1;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] imm_model(input logic [6:0] op);
    case (op)
      ST:      return 3'b001;
      BR:      return 3'b010;
      JL:      return 3'b011;
      LU:      return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic flag_cond(input logic [2:0] f3);
    case (f3)
      3'b000:  return ZeroE;
      3'b001:  return !ZeroE;
      3'b100:  return NegE ^ OvfE;
      3'b101:  return !(NegE ^ OvfE);
      3'b110:  return !CarryE;
      3'b111:  return CarryE;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic exp_pcsrc(input cw_t c);
    return c.jmp | (c.br & flag_cond(c.f3));
  endfunction

  task automatic check_all();
    chk("ALUControlE", ALUControlE, e_exp.alu);
    if (!(e_exp.jmp && !e_exp.pctsrc)) chk("ALUSrcE", ALUSrcE, e_exp.alusrc);
    chk("PCTargetSrcE", PCTargetSrcE, e_exp.pctsrc);
    chk("IllegalE", IllegalE, e_exp.ill | (e_exp.br & (e_exp.f3 == 3'b010 || e_exp.f3 == 3'b011)));
    chk("PCSrcE", PCSrcE, exp_pcsrc(e_exp));
    chk("RegWriteM", RegWriteM, m_exp.rw);
    chk("ResultSrcM", ResultSrcM, m_exp.rs);
    chk("MemWriteM", MemWriteM, m_exp.mw);
    chk("RegWriteW", RegWriteW, w_exp.rw);
    chk("ResultSrcW", ResultSrcW, w_exp.rs);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic fl);
    op_D = op; funct3_D = f3; funct7_5_D = f7; FlushE = fl;
    #1;
    chk("ImmSrcD", ImmSrcD, imm_model(op));
    chk("PCSrcE_pre", PCSrcE, exp_pcsrc(e_exp));
    qe.push_back(fl ? cw_t'('0) : model(op, f3, f7));
    @(posedge clk); #1;
    FlushE = 1'b0;
    w_exp = m_exp;
    m_exp = e_exp;
    e_exp = qe.pop_front();
    check_all();
    @(negedge clk);
  endtask

  // Flags derived from an actual A-B; expectation from a direct compare of A and B.
  task automatic branch_check(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] d;
    logic        taken;
    d = {1'b0, a} + {1'b0, ~b} + 33'd1;
    ZeroE  = (d[31:0] == 32'd0);
    NegE   = d[31];
    CarryE = d[32];
    OvfE   = (a[31] != b[31]) && (d[31] != a[31]);
    case (f3)
      3'b000:  taken = (a == b);
      3'b001:  taken = (a != b);
      3'b100:  taken = ($signed(a) < $signed(b));
      3'b101:  taken = ($signed(a) >= $signed(b));
      3'b110:  taken = (a < b);
      3'b111:  taken = (a >= b);
      default: taken = 1'b0;
    endcase
    #1;
    chk($sformatf("branch_f3_%0d_%0h_%0h", f3, a, b), PCSrcE, taken);
  endtask

  task automatic clear_model();
    qe.delete();
    e_exp = '0; m_exp = '0; w_exp = '0;
  endtask

  logic [31:0] pa [6] = '{32'd5, 32'd3, 32'd7, 32'hFFFFFFFF, 32'd1, 32'h80000000};
  logic [31:0] pb [6] = '{32'd5, 32'd7, 32'd3, 32'd1, 32'hFFFFFFFF, 32'h7FFFFFFF};
  logic [2:0]  bf3 [7] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010};
  logic [2:0]  rf3 [10] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b101, 3'b110, 3'b111};
  logic        rf7 [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    rst = 1'b1; op_D = '0; funct3_D = '0; funct7_5_D = 1'b0; FlushE = 1'b0;
    ZeroE = 1'b0; NegE = 1'b0; CarryE = 1'b0; OvfE = 1'b0;
    clear_model();
    #3;
    check_all();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // R-type sweep, then fillers so the last ones drain to Writeback
    for (int i = 0; i < 10; i++) issue(RT, rf3[i], rf7[i], 1'b0);
    issue(IA, 3'b000, 1'b1, 1'b0);
    issue(IA, 3'b101, 1'b1, 1'b0);
    issue(IA, 3'b101, 1'b0, 1'b0);
    issue(IA, 3'b010, 1'b0, 1'b0);
    issue(LD, 3'b010, 1'b0, 1'b0);
    issue(LD, 3'b010, 1'b0, 1'b0);
    issue(ST, 3'b010, 1'b0, 1'b0);
    issue(LU, 3'b000, 1'b0, 1'b0);

    // Branch matrix: flags swept while the branch sits in Execute
    for (int i = 0; i < 7; i++) begin
      issue(BR, bf3[i], 1'b0, 1'b0);
      for (int j = 0; j < 6; j++) branch_check(bf3[i], pa[j], pb[j]);
      ZeroE = 1'b0; NegE = 1'b0; CarryE = 1'b0; OvfE = 1'b0;
    end

    issue(JL, 3'b000, 1'b0, 1'b0);
    issue(JR, 3'b000, 1'b0, 1'b0);
    issue(IA, 3'b000, 1'b0, 1'b0);
    issue(IA, 3'b000, 1'b0, 1'b0);

    // Taken beq in Execute while the next transfer is flushed
    ZeroE = 1'b1;
    issue(BR, 3'b000, 1'b0, 1'b0);
    issue(LD, 3'b000, 1'b0, 1'b1);
    ZeroE = 1'b0;

    // Store followed by a flushed slot
    issue(ST, 3'b010, 1'b0, 1'b0);
    issue(ST, 3'b010, 1'b0, 1'b1);
    issue(IA, 3'b000, 1'b0, 1'b0);

    // Illegal opcode through the whole pipe
    issue(BAD, 3'b000, 1'b0, 1'b0);
    issue(BAD, 3'b111, 1'b1, 1'b0);
    issue(BAD, 3'b000, 1'b0, 1'b0);
    issue(BAD, 3'b000, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle during a load stream
    issue(LD, 3'b010, 1'b0, 1'b0);
    issue(LD, 3'b010, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    clear_model();
    check_all();
    @(posedge clk); #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    issue(LD, 3'b010, 1'b0, 1'b0);
    issue(IA, 3'b000, 1'b0, 1'b0);
    issue(IA, 3'b000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
# pipelined_control_unit

Parametrised pipelined RV32I control unit for the five-stage core. It decodes the instruction in Decode and carries the control word through Decode/Execute, Execute/Memory and Memory/Writeback registers. It resolves all six conditional branches plus JAL/JALR in Execute from the ALU flags, and supports hazard-unit bubble insertion. It replaces the single-cycle control unit, which decoded only a small opcode subset and resolved branches on Zero alone.

## Interface

Parameters:
- OP_WIDTH, 7, opcode width
- FUNCT3_WIDTH, 3, funct3 width
- ALU_CTRL_WIDTH, 4, ALU control width
- IMM_SRC_WIDTH, 3, immediate-format select width
- RESULT_SRC_WIDTH, 2, writeback-mux select width

Ports:
- clk  in  1  core clock; all registers update on rising edge
- rst  in  1  asynchronous, active-high reset
- op_D  in  OP_WIDTH  opcode of instruction in Decode
- funct3_D  in  FUNCT3_WIDTH  funct3 in Decode
- funct7_5_D  in  1  instr[30] in Decode
- FlushE  in  1  replace Decode→Execute transfer with bubble
- ZeroE, NegE, CarryE, OvfE  in  1 each  ALU flags of the Execute-stage compare (A−B)
- ImmSrcD  out  IMM_SRC_WIDTH  combinational: I=000 S=001 B=010 J=011 U=100
- ALUControlE  out  ALU_CTRL_WIDTH  registered ALU operation
- ALUSrcE  out  1  0=register B, 1=immediate
- PCSrcE  out  1  combinational redirect: JumpE | (BranchE & cond)
- PCTargetSrcE  out  1  0=PC+imm, 1=rs1+imm (JALR)
- MemWriteM  out  1  store enable in Memory
- RegWriteM, RegWriteW  out  1  register write enable per stage
- ResultSrcM, ResultSrcW  out  RESULT_SRC_WIDTH  00=ALU, 01=memory, 10=PC+4
- IllegalE  out  1  unrecognised opcode reached Execute

## Operation

- Decode table (op_D): 0000011 load; 0100011 store; 0110011 R-type; 0010011 I-ALU; 1100011 branch; 1101111 JAL; 1100111 JALR; 0110111 LUI. Any other opcode gives an all-zero control word with Illegal=1.
- ALU codes: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sltu 0110, sll 0111, srl 1000, sra 1001, passB 1010.
- funct3 mapping:
  - R-type: funct7_5=1 selects sub (f3=000) and sra (f3=101).
  - I-ALU: f3=101 uses funct7_5 for srl/sra; f3=000 is always add.
- Fixed ALU codes by opcode: load/store/JAL/JALR use add; branch uses sub; LUI uses passB.
- Control word per opcode (RegWrite/ALUSrc/MemWrite/ResultSrc/Branch/Jump/PCTargetSrc):
  - load: 1/1/0/01/0/0/0
  - store: 0/1/1/00/0/0/0
  - R-type: 1/0/0/00/0/0/0
  - I-ALU: 1/1/0/00/0/0/0
  - branch: 0/0/0/00/1/0/0
  - JAL: 1/x/0/10/0/1/0
  - JALR: 1/1/0/10/0/1/1
  - LUI: 1/1/0/00/0/0/0
- funct3_D is registered into Execute for branch resolution:
  - 000 beq: Z
  - 001 bne: !Z
  - 100 blt: N^V
  - 101 bge: !(N^V)
  - 110 bltu: !C
  - 111 bgeu: C (C = no-borrow)
  - 010/011: never taken; IllegalE is asserted.
- Pipeline registers:
  - D/E holds the full control word, funct3 and Illegal.
  - E/M holds RegWrite, ResultSrc and MemWrite.
  - M/W holds RegWrite and ResultSrc.
- FlushE=1 loads an all-zero word into D/E on the next edge. E/M and M/W advance normally.
- There is no stall input. The hazard unit holds Decode by stalling the instruction register upstream; the control path re-decodes the same instruction.

## Timing

- Reset: all register outputs are 0 immediately on rst rising (asynchronous). ALUControlE, ALUSrcE, PCTargetSrcE, IllegalE, MemWriteM, RegWriteM/W and ResultSrcM/W all read 0. PCSrcE=0 because BranchE=JumpE=0.
- rst has priority over FlushE. Reset asserted mid-stream discards every in-flight control word.
- Latency: op_D at edge n gives Execute outputs after edge n+1, Memory outputs after n+2 and Writeback outputs after n+3.
- ImmSrcD and PCSrcE are combinational. PCSrcE depends only on E registers and the current flags, within the same cycle.
- FlushE together with a taken branch in Execute: the branch still redirects this cycle and the next Execute holds a bubble.
- Back-to-back identical instructions must propagate independently with no stale-state carry-over.

## Test plan

- Reset check: pulse rst asynchronously mid-cycle during a load sequence -> all outputs 0 before the next edge; first instruction after release appears on E outputs one edge later.
- R-type sweep: add/sub/sll/slt/sltu/xor/srl/sra/or/and (0110011) -> ALUControlE = 0000/0001/0111/0101/0110/0100/1000/1001/0011/0010 one cycle later; RegWriteW=1 three cycles after issue.
- Branch matrix: all six branch funct3 values × flag sets. Example: blt with N=1, V=0 -> PCSrcE=1; bgeu with C=0 -> PCSrcE=0; funct3=010 -> PCSrcE=0 and IllegalE=1.
- Jumps: JAL -> PCSrcE=1, PCTargetSrcE=0, ResultSrcW=10. JALR -> PCTargetSrcE=1, ALUSrcE=1.
- Flush: store followed by FlushE=1 in the next cycle -> ALUSrcE/MemWrite bubble in Execute; the earlier store's MemWriteM=1 is unaffected.
- Illegal opcode 1111111 -> IllegalE=1, RegWriteM/W=0, MemWriteM=0 throughout.
